// File: rtl/or1200_alu_pkg.sv
// or1200_alu_pkg
// Shared types and helpers for the sequential OR1200 ALU:
//   alu_op_t    - ALU operation codes (4 bits)
//   shrot_op_t  - shift/rotate sub-operation (2 bits)
//   COMP_*      - comparison selectors for comp_op[2:0]; comp_op[3] selects signed
//   div_state_t - divider FSM states
//   clog2       - constant ceil(log2) helper for parameter arithmetic
package or1200_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_ADDC  = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SHROT = 4'd6,
    ALU_IMM   = 4'd7,
    ALU_MOVHI = 4'd8,
    ALU_CMOV  = 4'd9,
    ALU_FF1   = 4'd10,
    ALU_FL1   = 4'd11,
    ALU_COMP  = 4'd12,
    ALU_DIV   = 4'd13,
    ALU_DIVU  = 4'd14
  } alu_op_t;

  typedef enum logic [1:0] {
    SHROT_SLL = 2'd0,
    SHROT_SRL = 2'd1,
    SHROT_SRA = 2'd2,
    SHROT_ROR = 2'd3
  } shrot_op_t;

  localparam logic [2:0] COMP_EQ = 3'd0;
  localparam logic [2:0] COMP_NE = 3'd1;
  localparam logic [2:0] COMP_GT = 3'd2;
  localparam logic [2:0] COMP_GE = 3'd3;
  localparam logic [2:0] COMP_LT = 3'd4;
  localparam logic [2:0] COMP_LE = 3'd5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/or1200_alu_div.sv
// or1200_alu_div
// Iterative restoring divider, DIV_BPC quotient bits per cycle.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             begin a divide (only honoured in IDLE, divisor nonzero)
//   i_signed            treat operands as two's complement
//   i_kill              abort; returns to IDLE on the next edge
//   i_a, i_b            dividend, divisor (sampled on i_start)
//   o_busy              FSM is not IDLE
//   o_done              FIX cycle: o_quotient/o_ovf are final this cycle
//   o_quotient          signed-corrected quotient
//   o_ovf               MIN / -1 overflow of a signed divide
module or1200_alu_div #(
  parameter int WIDTH   = 32,
  parameter int DIV_BPC = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic             i_kill,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic             o_ovf
);
  import or1200_alu_pkg::*;

  localparam int STEPS = WIDTH / DIV_BPC;
  localparam int CW    = clog2(STEPS) + 1;
  localparam logic [CW-1:0]    LAST    = CW'(STEPS - 1);
  localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;   // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] r_div;
  logic             r_neg;
  logic             r_ovf;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH:0]   w_trial;

  // Operand magnitudes; MIN maps to 2**(WIDTH-1) which still fits unsigned.
  always_comb begin
    if (i_signed && i_a[WIDTH-1]) begin
      w_a_mag = ~i_a + ONE;
    end else begin
      w_a_mag = i_a;
    end
    if (i_signed && i_b[WIDTH-1]) begin
      w_b_mag = ~i_b + ONE;
    end else begin
      w_b_mag = i_b;
    end
  end

  // DIV_BPC restoring steps chained within one cycle.
  always_comb begin
    w_rem_nx = r_rem;
    w_quo_nx = r_quo;
    w_trial  = {(WIDTH+1){1'b0}};
    for (int k = 0; k < DIV_BPC; k++) begin
      w_trial = {w_rem_nx, w_quo_nx[WIDTH-1]};
      if (w_trial >= {1'b0, r_div}) begin
        w_rem_nx = WIDTH'(w_trial - {1'b0, r_div});
        w_quo_nx = {w_quo_nx[WIDTH-2:0], 1'b1};
      end else begin
        w_rem_nx = w_trial[WIDTH-1:0];
        w_quo_nx = {w_quo_nx[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Divider FSM, step counter and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_rem   <= {WIDTH{1'b0}};
      r_quo   <= {WIDTH{1'b0}};
      r_div   <= {WIDTH{1'b0}};
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_kill) begin
      r_state <= DIV_IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (i_start) begin
            r_state <= DIV_CALC;
            r_cnt   <= {CW{1'b0}};
            r_rem   <= {WIDTH{1'b0}};
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_neg   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_ovf   <= i_signed & (i_a == MIN_VAL) & (i_b == {WIDTH{1'b1}});
          end else begin
            r_state <= DIV_IDLE;
          end
        end
        DIV_CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          if (r_cnt == LAST) begin
            r_state <= DIV_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        DIV_FIX: begin
          r_state <= DIV_IDLE;
          r_cnt   <= {CW{1'b0}};
        end
        default: begin
          r_state <= DIV_IDLE;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Status and sign-corrected quotient; the parent registers these during FIX.
  always_comb begin
    o_busy = (r_state != DIV_IDLE);
    o_done = (r_state == DIV_FIX);
    o_ovf  = r_ovf;
    if (r_neg) begin
      o_quotient = ~r_quo + ONE;
    end else begin
      o_quotient = r_quo;
    end
  end

endmodule

// File: rtl/or1200_alu_seq.sv
// or1200_alu_seq
// Registered-output OR1200 integer ALU with overflow, FF1/FL1 and an
// iterative divider behind a valid/ready handshake.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_in_valid / o_in_ready   request handshake; ready drops while dividing
//   i_kill                    pipeline flush, aborts divide, drops request
//   i_alu_op, i_shrot_op, i_comp_op   operation selectors
//   i_a, i_b                  operands
//   i_carry_in, i_flag_in     SR[CY] for ADDC, SR[F] for CMOV
//   o_out_valid               outputs below are valid this cycle
//   o_result                  result
//   o_flag/_we, o_cy/_we, o_ov/_we    SR flag updates
module or1200_alu_seq #(
  parameter int WIDTH   = 32,
  parameter int DIV_BPC = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_kill,
  input  logic [3:0]       i_alu_op,
  input  logic [1:0]       i_shrot_op,
  input  logic [3:0]       i_comp_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  input  logic             i_flag_in,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_flag,
  output logic             o_flag_we,
  output logic             o_cy,
  output logic             o_cy_we,
  output logic             o_ov,
  output logic             o_ov_we
);
  import or1200_alu_pkg::*;

  localparam int SHW = clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_op_t          w_op;
  logic             w_accept;
  logic             w_is_div;
  logic             w_b_zero;
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_div_quo;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_ff1;
  logic [WIDTH-1:0] w_fl1;
  logic             w_eq;
  logic             w_lt;
  logic             w_cmp;
  logic [WIDTH-1:0] w_res;
  logic             w_flag;
  logic             w_flag_we;
  logic             w_cy;
  logic             w_cy_we;
  logic             w_ov;
  logic             w_ov_we;

  assign w_op        = alu_op_t'(i_alu_op);
  assign o_in_ready  = ~w_div_busy;
  assign w_accept    = i_in_valid & o_in_ready & ~i_kill;
  assign w_is_div    = (w_op == ALU_DIV) || (w_op == ALU_DIVU);
  assign w_b_zero    = (i_b == {WIDTH{1'b0}});
  // Divide by zero bypasses the FSM and completes like a single-cycle op.
  assign w_div_start = w_accept & w_is_div & ~w_b_zero;

  assign w_cin   = (w_op == ALU_ADDC) & i_carry_in;
  assign w_sum   = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
  assign w_shamt = i_b[SHW-1:0];
  // Rotate by shifting the doubled operand; shamt 0 naturally yields a.
  assign w_ror   = WIDTH'({i_a, i_a} >> w_shamt);
  assign w_eq    = (i_a == i_b);

  or1200_alu_div #(
    .WIDTH   (WIDTH),
    .DIV_BPC (DIV_BPC)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (w_div_start),
    .i_signed   (w_op == ALU_DIV),
    .i_kill     (i_kill),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_div_quo),
    .o_ovf      (w_div_ovf)
  );

  // Find-first-one / find-last-one as 1-based bit indices, 0 when a is zero.
  always_comb begin
    w_ff1 = {WIDTH{1'b0}};
    w_fl1 = {WIDTH{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_ff1 = i_a[i] ? WIDTH'(i + 1) : w_ff1;
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_fl1 = i_a[i] ? WIDTH'(i + 1) : w_fl1;
    end
  end

  // Comparison outcome for COMP.
  always_comb begin
    if (i_comp_op[3]) begin
      w_lt = ($signed(i_a) < $signed(i_b));
    end else begin
      w_lt = (i_a < i_b);
    end
    case (i_comp_op[2:0])
      COMP_EQ: w_cmp = w_eq;
      COMP_NE: w_cmp = ~w_eq;
      COMP_GT: w_cmp = ~w_lt & ~w_eq;
      COMP_GE: w_cmp = ~w_lt;
      COMP_LT: w_cmp = w_lt;
      COMP_LE: w_cmp = w_lt | w_eq;
      default: w_cmp = 1'b0;
    endcase
  end

  // Single-cycle result and flag updates for the op on the inputs.
  always_comb begin
    w_res     = {WIDTH{1'b0}};
    w_flag    = 1'b0;
    w_flag_we = 1'b0;
    w_cy      = 1'b0;
    w_cy_we   = 1'b0;
    w_ov      = 1'b0;
    w_ov_we   = 1'b0;
    case (w_op)
      ALU_ADD, ALU_ADDC: begin
        w_res   = w_sum[MSB:0];
        w_cy    = w_sum[WIDTH];
        w_cy_we = 1'b1;
        w_ov    = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
        w_ov_we = 1'b1;
      end
      ALU_SUB: begin
        w_res   = w_diff[MSB:0];
        w_cy    = w_diff[WIDTH];
        w_cy_we = 1'b1;
        w_ov    = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
        w_ov_we = 1'b1;
      end
      ALU_AND:   w_res = i_a & i_b;
      ALU_OR:    w_res = i_a | i_b;
      ALU_XOR:   w_res = i_a ^ i_b;
      ALU_SHROT: begin
        case (shrot_op_t'(i_shrot_op))
          SHROT_SLL: w_res = i_a << w_shamt;
          SHROT_SRL: w_res = i_a >> w_shamt;
          SHROT_SRA: w_res = $signed(i_a) >>> w_shamt;
          SHROT_ROR: w_res = w_ror;
          default:   w_res = {WIDTH{1'b0}};
        endcase
      end
      ALU_IMM:   w_res = i_b;
      ALU_MOVHI: w_res = i_b << 5'd16;
      ALU_CMOV: begin
        if (i_flag_in) begin
          w_res = i_a;
        end else begin
          w_res = i_b;
        end
      end
      ALU_FF1:   w_res = w_ff1;
      ALU_FL1:   w_res = w_fl1;
      ALU_COMP: begin
        w_flag    = w_cmp;
        w_flag_we = 1'b1;
      end
      ALU_DIV, ALU_DIVU: begin
        // Only reaches the outputs for a zero divisor.
        w_ov    = 1'b1;
        w_ov_we = 1'b1;
      end
      default: w_res = {WIDTH{1'b0}};
    endcase
  end

  // Output registers: kill wins, then divider completion, then single-cycle ops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out_valid <= 1'b0;
      o_result    <= {WIDTH{1'b0}};
      o_flag      <= 1'b0;
      o_flag_we   <= 1'b0;
      o_cy        <= 1'b0;
      o_cy_we     <= 1'b0;
      o_ov        <= 1'b0;
      o_ov_we     <= 1'b0;
    end else if (i_kill) begin
      o_out_valid <= 1'b0;
      o_flag_we   <= 1'b0;
      o_cy_we     <= 1'b0;
      o_ov_we     <= 1'b0;
    end else if (w_div_done) begin
      o_out_valid <= 1'b1;
      o_result    <= w_div_quo;
      o_flag_we   <= 1'b0;
      o_cy_we     <= 1'b0;
      o_ov        <= w_div_ovf;
      o_ov_we     <= 1'b1;
    end else if (w_accept && !w_div_start) begin
      o_out_valid <= 1'b1;
      o_result    <= w_res;
      o_flag      <= w_flag;
      o_flag_we   <= w_flag_we;
      o_cy        <= w_cy;
      o_cy_we     <= w_cy_we;
      o_ov        <= w_ov;
      o_ov_we     <= w_ov_we;
    end else begin
      o_out_valid <= 1'b0;
      o_flag_we   <= 1'b0;
      o_cy_we     <= 1'b0;
      o_ov_we     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_or1200_alu_seq.sv
// tb_or1200_alu_seq
// Directed bench for or1200_alu_seq. Two instances share stimulus: u_dut
// (DIV_BPC=1) and u_dut2 (DIV_BPC=2) so divide latency is checked for both.
module tb_or1200_alu_seq;
  import or1200_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        kill;
  logic [3:0]  alu_op;
  logic [1:0]  shrot_op;
  logic [3:0]  comp_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        carry_in;
  logic        flag_in;

  logic        in_ready,  out_valid,  flag,  flag_we,  cy,  cy_we,  ov,  ov_we;
  logic [31:0] result;
  logic        in_ready2, out_valid2, flag2, flag_we2, cy2, cy_we2, ov2, ov_we2;
  logic [31:0] result2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  or1200_alu_seq #(.WIDTH(32), .DIV_BPC(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_kill(kill), .i_alu_op(alu_op), .i_shrot_op(shrot_op), .i_comp_op(comp_op),
    .i_a(a), .i_b(b), .i_carry_in(carry_in), .i_flag_in(flag_in),
    .o_out_valid(out_valid), .o_result(result), .o_flag(flag), .o_flag_we(flag_we),
    .o_cy(cy), .o_cy_we(cy_we), .o_ov(ov), .o_ov_we(ov_we)
  );

  or1200_alu_seq #(.WIDTH(32), .DIV_BPC(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready2),
    .i_kill(kill), .i_alu_op(alu_op), .i_shrot_op(shrot_op), .i_comp_op(comp_op),
    .i_a(a), .i_b(b), .i_carry_in(carry_in), .i_flag_in(flag_in),
    .o_out_valid(out_valid2), .o_result(result2), .o_flag(flag2), .o_flag_we(flag_we2),
    .o_cy(cy2), .o_cy_we(cy_we2), .o_ov(ov2), .o_ov_we(ov_we2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then withdraw it.
  task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
    alu_op   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int lat1;
    int lat2;
    int rdy_bad;
    int early;
    logic [31:0] res1;
    logic [31:0] res2;
    logic        ov1;

    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; alu_op = 4'd0; shrot_op = 2'd0;
    comp_op = 4'd0; a = 32'd0; b = 32'd0; carry_in = 1'b0; flag_in = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;

    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", result, 32'h0);
    chk("rst_we", {flag_we, cy_we, ov_we, ov}, 4'b0000);

    // ADD overflow
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_valid", out_valid, 1'b1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_cy", {cy, cy_we}, 2'b01);
    chk("add_ov", {ov, ov_we}, 2'b11);
    tick();
    chk("add_valid_one_cycle", out_valid, 1'b0);

    // ADDC with carry in
    carry_in = 1'b1;
    issue(ALU_ADDC, 32'hFFFF_FFFF, 32'h0000_0000);
    carry_in = 1'b0;
    chk("addc_result", result, 32'h0);
    chk("addc_cy_ov", {cy, ov}, 2'b10);

    // SUB with borrow
    issue(ALU_SUB, 32'h0000_0003, 32'h0000_0005);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_cy_ov", {cy, cy_we, ov, ov_we}, 4'b1101);

    // FF1 / FL1 back to back
    issue(ALU_FF1, 32'h0001_0100, 32'h0);
    chk("ff1", result, 32'd9);
    issue(ALU_FL1, 32'h0001_0100, 32'h0);
    chk("fl1", result, 32'd17);
    chk("fl1_no_we", {flag_we, cy_we, ov_we}, 3'b000);
    issue(ALU_FF1, 32'h0, 32'h0);
    chk("ff1_zero", result, 32'd0);
    issue(ALU_FL1, 32'h0, 32'h0);
    chk("fl1_zero", result, 32'd0);

    // Shifts / rotates
    shrot_op = SHROT_ROR;
    issue(ALU_SHROT, 32'h0000_0001, 32'h0000_0001);
    chk("ror_1", result, 32'h8000_0000);
    issue(ALU_SHROT, 32'h1234_5678, 32'h0000_0020);
    chk("ror_0", result, 32'h1234_5678);
    shrot_op = SHROT_SRA;
    issue(ALU_SHROT, 32'h8000_0000, 32'h0000_0004);
    chk("sra", result, 32'hF800_0000);

    // Misc single-cycle ops
    issue(ALU_MOVHI, 32'h0, 32'h0000_1234);
    chk("movhi", result, 32'h1234_0000);
    flag_in = 1'b1;
    issue(ALU_CMOV, 32'hAAAA_0000, 32'h0000_5555);
    chk("cmov_f1", result, 32'hAAAA_0000);
    flag_in = 1'b0;
    issue(ALU_CMOV, 32'hAAAA_0000, 32'h0000_5555);
    chk("cmov_f0", result, 32'h0000_5555);
    issue(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("xor", result, 32'h0FF0_0FF0);

    // Compares: signed vs unsigned LT on -1 vs 1
    comp_op = {1'b1, COMP_LT};
    issue(ALU_COMP, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("comp_slt", {result, flag, flag_we}, {32'h0, 2'b11});
    comp_op = {1'b0, COMP_LT};
    issue(ALU_COMP, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("comp_ult", {flag, flag_we}, 2'b01);
    comp_op = {1'b0, COMP_GE};
    issue(ALU_COMP, 32'h0000_0007, 32'h0000_0007);
    chk("comp_uge", {flag, flag_we}, 2'b11);

    // DIV -100 / 7, latency 34 (BPC=1) and 18 (BPC=2)
    issue(ALU_DIV, 32'hFFFF_FF9C, 32'h0000_0007);
    lat1 = 0; lat2 = 0; rdy_bad = 0; res1 = 32'h0; res2 = 32'h0; ov1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (out_valid && lat1 == 0) begin lat1 = c; res1 = result; ov1 = ov; end
      if (out_valid2 && lat2 == 0) begin lat2 = c; res2 = result2; end
      if (c <= 33 && in_ready) rdy_bad++;
      if (lat1 != 0 && lat2 != 0) break;
      tick();
    end
    chk("div_latency", lat1, 34);
    chk("div_latency_bpc2", lat2, 18);
    chk("div_ready_low", rdy_bad, 0);
    chk("div_ready_back", in_ready, 1'b1);
    chk("div_result", res1, 32'hFFFF_FFF2);
    chk("div_result_bpc2", res2, 32'hFFFF_FFF2);
    chk("div_ov", {ov1, ov_we, cy_we, flag_we}, 4'b0100);

    // DIVU by zero: immediate
    issue(ALU_DIVU, 32'h0000_1234, 32'h0);
    chk("div0_valid", {out_valid, in_ready}, 2'b11);
    chk("div0_result", result, 32'h0);
    chk("div0_ov", {ov, ov_we}, 2'b11);

    // DIV MIN / -1
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    lat1 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (out_valid) begin lat1 = c; break; end
      tick();
    end
    chk("divmin_latency", lat1, 34);
    chk("divmin_result", result, 32'h8000_0000);
    chk("divmin_ov", {ov, ov_we}, 2'b11);

    // DIVU 0xFFFFFFFF / 2
    issue(ALU_DIVU, 32'hFFFF_FFFF, 32'h0000_0002);
    lat1 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (out_valid) begin lat1 = c; break; end
      tick();
    end
    chk("divu_latency", lat1, 34);
    chk("divu_result", {result, ov}, {32'h7FFF_FFFF, 1'b0});

    // Kill a divide in progress at cycle 10
    issue(ALU_DIV, 32'h0000_03E8, 32'h0000_0003);
    early = 0;
    for (int c = 1; c <= 9; c++) begin
      if (out_valid || out_valid2) early++;
      tick();
    end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_no_valid", {early, out_valid, out_valid2}, 34'h0);
    chk("kill_ready", {in_ready, in_ready2}, 2'b11);
    issue(ALU_ADD, 32'h0000_0005, 32'h0000_0006);
    chk("kill_add_valid", out_valid, 1'b1);
    chk("kill_add_result", result, 32'd11);
    tick();
    early = 0;
    for (int c = 1; c <= 40; c++) begin
      if (out_valid) early++;
      tick();
    end
    chk("kill_no_late_valid", early, 0);

    // kill together with a request: dropped
    kill = 1'b1;
    issue(ALU_ADD, 32'h0000_0001, 32'h0000_0001);
    kill = 1'b0;
    chk("kill_drop", out_valid, 1'b0);
    chk("kill_drop_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
